pwm_env_ctrl: RTL
=================

PWM_ENV_CTRL -- requirements
Module: pwm_env_ctrl

Interface
REQ-001 Parameter STEP_CYCLES, default 392: clock cycles between duty-cycle updates; legal range 2..65535.
REQ-002 clk_in  input  1  system clock; all state updates on its rising edge.
REQ-003 rst_n_in  input  1  reset, asynchronous assert, active-low.
REQ-004 cmd_valid_in  input  1  command present.
REQ-005 cmd_ready_out  output  1  command accepted when cmd_valid_in and cmd_ready_out are both high on a rising edge.
REQ-006 cmd_on_in  input  1  1 = note-on, 0 = note-off.
REQ-007 cmd_level_in  input  8  note-on target duty; ignored for note-off.
REQ-008 attack_step_in  input  8  duty increment/decrement per tick during ATTACK; sampled only at accept.
REQ-009 release_step_in  input  8  duty decrement per tick during RELEASE; sampled only at accept.
REQ-010 dc_out  output  8  registered duty cycle that drives the PWM duty input.
REQ-011 state_out  output  2  current state encoding: IDLE=0, ATTACK=1, HOLD=2, RELEASE=3.
REQ-012 done_out  output  1  single-cycle pulse when RELEASE reaches 0.

Function
REQ-013 States IDLE, ATTACK, HOLD, RELEASE; registers: state, dc, target, att_step, rel_step, tick counter.
REQ-014 cmd_ready_out high in IDLE, HOLD and RELEASE; low in ATTACK.
REQ-015 On accept, the block registers the step inputs; a step value of 0 is stored as 1.
REQ-016 Note-on with level > 0 sets target=level and enters ATTACK on the next cycle from the current dc; dc_out does not jump.
REQ-017 Note-on with level 0 behaves exactly as note-off.
REQ-018 Note-off in HOLD or RELEASE enters RELEASE on the next cycle; note-off in IDLE is accepted and causes no change.
REQ-019 The tick counter restarts at 0 on every accept.
REQ-020 Otherwise the tick counter counts 0..STEP_CYCLES-1 and wraps; a tick fires on the cycle the count equals STEP_CYCLES-1.
REQ-021 The first dc update after an accept therefore occurs exactly STEP_CYCLES cycles after the accept edge.
REQ-022 ATTACK tick when dc<target: dc = min(dc+att_step, target), computed 9 bits wide and saturating; no 8-bit wrap.
REQ-023 ATTACK tick when dc>target: dc = max(dc-att_step, target), computed without underflow.
REQ-024 When dc==target in ATTACK (including on accept), the next cycle enters HOLD.
REQ-025 HOLD keeps dc constant indefinitely.
REQ-026 RELEASE tick: dc = max(dc-rel_step, 0).
REQ-027 In the cycle dc reaches 0 in RELEASE, the next cycle enters IDLE with done_out=1 for that one cycle.
REQ-028 RELEASE entered with dc already 0 goes to IDLE on the next cycle and pulses done_out.
REQ-029 An accept that coincides with a tick takes priority; that tick's dc update is discarded.
REQ-030 dc_out, state_out and done_out are registered outputs with no combinational path from any input.

Reset
REQ-031 While rst_n_in is low: state=IDLE, dc_out=0, done_out=0, tick count=0, target=0, stored steps=1, cmd_ready_out=1 immediately (asynchronous).
REQ-032 Deassertion mid-envelope resumes in IDLE with dc_out=0; no done_out pulse is generated by reset.

Structure
REQ-033 Shared package pwm_ctrl_pkg holds the state enum (2-bit) and the constant DEFAULT_STEP_CYCLES=392, and is reused by other PWM controllers.
REQ-034 Tick generation is a sub-module pwm_tick_gen (ports clk_in, rst_n_in, restart_in, tick_out; parameter STEP_CYCLES).
REQ-035 Envelope FSM and arithmetic live in pwm_env_ctrl; target RTL size is 120-400 lines in total.

Verification (STEP_CYCLES=4 unless noted)
REQ-036 Reset: after rst_n_in release -> dc_out=0, state_out=0, cmd_ready_out=1, done_out=0.
REQ-037 Attack: note-on level=10, attack_step=4 -> dc_out 4,8,10 at 4, 8, 12 cycles after accept; then HOLD; cmd_ready_out low until HOLD.
REQ-038 Saturation: note-on level=255, attack_step=200 -> dc_out 200 then 255 (never wraps); HOLD.
REQ-039 Release: from HOLD at dc=10, note-off with release_step=3 -> dc_out 7,4,1,0; exactly one done_out pulse; state IDLE.
REQ-040 Retarget: in RELEASE at dc=7, note-on level=5, attack_step=1 -> dc_out 6 then 5, then HOLD; no done_out pulse.
REQ-041 Async reset: assert rst_n_in mid-ATTACK between clock edges -> dc_out=0 and state_out=0 before the next edge.

Source files
------------

// File: rtl/pwm_ctrl_pkg.sv
// Shared definitions for the PWM controller family: the envelope state encoding,
// the default tick period and a small step-sanitising helper.
package pwm_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ATTACK  = 2'd1,
    ST_HOLD    = 2'd2,
    ST_RELEASE = 2'd3
  } env_state_t;

  localparam int DEFAULT_STEP_CYCLES = 392;

  // A zero step would stall the envelope forever, so it is promoted to 1.
  function automatic logic [7:0] nz_step(input logic [7:0] step);
    return (step == 8'd0) ? 8'd1 : step;
  endfunction

endpackage

// File: rtl/pwm_tick_gen.sv
// Free-running modulo-STEP_CYCLES counter; tick_out is high during the last count
// of each period, and restart_in forces the count back to 0.
module pwm_tick_gen
  import pwm_ctrl_pkg::*;
#(
  parameter int STEP_CYCLES = DEFAULT_STEP_CYCLES
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic restart_in,
  output logic tick_out
);

  localparam logic [15:0] LAST_COUNT = 16'(STEP_CYCLES - 1);

  logic [15:0] count;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      count <= 16'd0;
    end else if (restart_in || (count == LAST_COUNT)) begin
      count <= 16'd0;
    end else begin
      count <= count + 16'd1;
    end
  end

  assign tick_out = (count == LAST_COUNT);

endmodule

// File: rtl/pwm_env_ctrl.sv
// Envelope controller: ramps a registered PWM duty toward a note-on target
// (ATTACK/HOLD) and back to zero on note-off (RELEASE), one step per tick.
module pwm_env_ctrl
  import pwm_ctrl_pkg::*;
#(
  parameter int STEP_CYCLES = DEFAULT_STEP_CYCLES
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       cmd_valid_in,
  output logic       cmd_ready_out,
  input  logic       cmd_on_in,
  input  logic [7:0] cmd_level_in,
  input  logic [7:0] attack_step_in,
  input  logic [7:0] release_step_in,
  output logic [7:0] dc_out,
  output logic [1:0] state_out,
  output logic       done_out
);

  env_state_t state;
  logic [7:0] dc;
  logic [7:0] target;
  logic [7:0] att_step;
  logic [7:0] rel_step;
  logic       done;

  logic       accept;
  logic       note_on;
  logic       tick;
  logic [8:0] up_sum;
  logic [8:0] down_floor;
  logic [7:0] attack_next;
  logic [7:0] release_next;

  assign cmd_ready_out = (state != ST_ATTACK);
  assign accept        = cmd_valid_in && cmd_ready_out;
  assign note_on       = cmd_on_in && (cmd_level_in != 8'd0);

  pwm_tick_gen #(
    .STEP_CYCLES(STEP_CYCLES)
  ) u_tick_gen (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .restart_in(accept),
    .tick_out  (tick)
  );

  // Both directions are clamped at the target in 9 bits so nothing wraps.
  assign up_sum      = {1'b0, dc} + {1'b0, att_step};
  assign down_floor  = {1'b0, target} + {1'b0, att_step};
  assign attack_next = (dc < target)
                       ? ((up_sum >= {1'b0, target}) ? target : up_sum[7:0])
                       : (({1'b0, dc} <= down_floor) ? target : (dc - att_step));
  assign release_next = (dc <= rel_step) ? 8'd0 : (dc - rel_step);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state    <= ST_IDLE;
      dc       <= 8'd0;
      target   <= 8'd0;
      att_step <= 8'd1;
      rel_step <= 8'd1;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        // An accept wins over a coincident tick; that tick's update is dropped.
        att_step <= nz_step(attack_step_in);
        rel_step <= nz_step(release_step_in);
        if (note_on) begin
          target <= cmd_level_in;
          state  <= ST_ATTACK;
        end else if (state != ST_IDLE) begin
          state <= ST_RELEASE;
        end
      end else begin
        case (state)
          ST_ATTACK: begin
            if (dc == target) begin
              state <= ST_HOLD;
            end else if (tick) begin
              dc <= attack_next;
            end
          end
          ST_RELEASE: begin
            if (dc == 8'd0) begin
              state <= ST_IDLE;
              done  <= 1'b1;
            end else if (tick) begin
              dc <= release_next;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign dc_out    = dc;
  assign state_out = state;
  assign done_out  = done;

endmodule
